temporizador_regressivo: RTL and testbench
==========================================

TEMPORIZADOR_REGRESSIVO -- requirements
Module: temporizador_regressivo

Interface
REQ-001 The block SHALL have parameter ALARM_TICKS, default 300, giving the number of clk_100hz cycles the alarm output stays high (300 = 3 s).
REQ-002 The block SHALL have port clk_100hz  input  1  100 Hz clock; one count step per rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port load  input  1  one-cycle request to capture the preset digits.
REQ-005 The block SHALL have port start_stop  input  1  one-cycle toggle request for run and pause.
REQ-006 The block SHALL have ports p_cs_unidade, p_cs_dezena, p_s_unidade, p_s_dezena  input  4 each  BCD preset value.
REQ-007 The block SHALL have ports cs_unidade, cs_dezena, s_unidade, s_dezena  output  4 each  current remaining time in BCD.
REQ-008 The block SHALL have port rodando  output  1  high while in state RUN.
REQ-009 The block SHALL have port alarme  output  1  high while in state ALARM.
REQ-010 The block SHALL have port erro  output  1  sticky flag for a rejected (invalid) preset.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, PAUSE and ALARM, and all transitions SHALL occur on the rising edge of clk_100hz.
REQ-012 A preset SHALL be valid only when both centisecond digits are ≤9, s_unidade is ≤9 and s_dezena is ≤5.
REQ-013 When load=1 in IDLE, PAUSE or ALARM, the following SHALL apply:
- valid preset: capture it into the count, clear erro, next state IDLE;
- invalid preset: leave the count unchanged, set erro, keep the current state.
REQ-014 load SHALL be ignored in RUN.
REQ-015 When load and start_stop are both 1 in the same cycle, load SHALL take priority and start_stop SHALL be ignored.
REQ-016 start_stop=1 SHALL produce these transitions:
- IDLE with nonzero count: go to RUN;
- IDLE with count 00:00: stay in IDLE;
- RUN: go to PAUSE;
- PAUSE: go to RUN;
- ALARM: go to IDLE as an early acknowledge.
REQ-017 In RUN, the count SHALL decrement by exactly one centisecond per clock edge, with BCD borrow applied as follows:
- cs_unidade 0→9, borrowing from cs_dezena;
- cs 00→99, borrowing from the seconds;
- s_unidade 0→9, borrowing from s_dezena.
REQ-018 When the count in RUN is 00:01, the next edge SHALL make the count 00:00 and the state ALARM on that same edge; the count SHALL never wrap below 00:00.
REQ-019 ALARM SHALL hold the count at 00:00, and after exactly ALARM_TICKS cycles in ALARM the state SHALL return to IDLE.
REQ-020 The alarm duration counter SHALL be $clog2(ALARM_TICKS+1) bits wide and SHALL clear on every entry to ALARM.
REQ-021 In IDLE and PAUSE, the count SHALL hold its value.
REQ-022 All outputs SHALL be registered, and rodando and alarme SHALL be decoded directly from the state register.

Reset
REQ-023 On reset=1 at a clock edge, the block SHALL enter IDLE, zero all four digits, and clear erro, rodando, alarme and the alarm duration counter.
REQ-024 reset SHALL override load and start_stop in the same cycle, including a reset asserted mid-RUN or mid-ALARM.

Structure
REQ-025 A shared package SHALL hold the state encoding constants and the BCD limit constants (9 and 5).
REQ-026 One sub-module, decrementador_bcd, SHALL implement a single-digit BCD decrement with borrow-in, borrow-out and a configurable maximum digit; four instances SHALL be chained.

Verification
REQ-027 Scenario 1: load 00:05 (valid), pulse start_stop → 00:04, 00:03, 00:02, 00:01, 00:00 on the next 5 edges; alarme rises on edge 5, stays high for 300 cycles, then IDLE.
REQ-028 Scenario 2: load 10:00 and run for one edge → 09:99; load 00:00 and pulse start_stop → stays in IDLE, rodando=0.
REQ-029 Scenario 3: load 00:50, run 3 edges, pulse start_stop → count frozen at 00:47 in PAUSE; pulse again → resumes at 00:46.
REQ-030 Scenario 4: load with p_s_dezena=6 → erro=1, count and state unchanged; a later valid load → erro=0.
REQ-031 Scenario 5: reset during RUN at 12:34 → next edge shows 00:00, IDLE, all flags 0; load and start_stop together in IDLE → load wins, state stays IDLE.
REQ-032 Scenario 6: pulse start_stop two cycles into ALARM → IDLE on the next edge and alarme=0.

Source files
------------

// File: rtl/temporizador_regressivo_pkg.sv
// Shared definitions for the countdown timer: FSM encoding, BCD digit limits
// and the preset validity rule.
package temporizador_regressivo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } estado_t;

  localparam logic [3:0] BCD_MAX_UNIDADE  = 4'd9;
  localparam logic [3:0] BCD_MAX_DEZENA_S = 4'd5;

  // Digit positions inside the count array, least significant first.
  localparam int NUM_DIGITOS = 4;
  localparam int DIG_CS_U    = 0;
  localparam int DIG_CS_D    = 1;
  localparam int DIG_S_U     = 2;
  localparam int DIG_S_D     = 3;

  function automatic logic [3:0] max_digito(input int idx);
    return (idx == DIG_S_D) ? BCD_MAX_DEZENA_S : BCD_MAX_UNIDADE;
  endfunction

  function automatic logic preset_valido(input logic [3:0] cs_u,
                                         input logic [3:0] cs_d,
                                         input logic [3:0] s_u,
                                         input logic [3:0] s_d);
    return (cs_u <= BCD_MAX_UNIDADE) && (cs_d <= BCD_MAX_UNIDADE) &&
           (s_u <= BCD_MAX_UNIDADE) && (s_d <= BCD_MAX_DEZENA_S);
  endfunction

endpackage

// File: rtl/temporizador_regressivo_if.sv
// Control, preset and status signals of the countdown timer; the timer is the
// slave, whoever drives load/start_stop and the preset is the master.
interface temporizador_regressivo_if;
  logic       load;
  logic       start_stop;
  logic [3:0] p_cs_unidade;
  logic [3:0] p_cs_dezena;
  logic [3:0] p_s_unidade;
  logic [3:0] p_s_dezena;
  logic [3:0] cs_unidade;
  logic [3:0] cs_dezena;
  logic [3:0] s_unidade;
  logic [3:0] s_dezena;
  logic       rodando;
  logic       alarme;
  logic       erro;

  modport master (
    output load, start_stop, p_cs_unidade, p_cs_dezena, p_s_unidade, p_s_dezena,
    input  cs_unidade, cs_dezena, s_unidade, s_dezena, rodando, alarme, erro
  );

  modport slave (
    input  load, start_stop, p_cs_unidade, p_cs_dezena, p_s_unidade, p_s_dezena,
    output cs_unidade, cs_dezena, s_unidade, s_dezena, rodando, alarme, erro
  );
endinterface

// File: rtl/decrementador_bcd.sv
// One BCD digit of the countdown chain: subtracts borrow_in, wrapping 0 to
// MAX_DIGIT and raising borrow_out for the next digit up.
module decrementador_bcd
  import temporizador_regressivo_pkg::*;
#(
  parameter logic [3:0] MAX_DIGIT = BCD_MAX_UNIDADE
) (
  input  logic [3:0] digito,
  input  logic       borrow_in,
  output logic [3:0] digito_dec,
  output logic       borrow_out
);

  always_comb begin
    digito_dec = digito;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digito == 4'd0) begin
        digito_dec = MAX_DIGIT;
        borrow_out = 1'b1;
      end else begin
        digito_dec = digito - 4'd1;
      end
    end
  end

endmodule

// File: rtl/temporizador_regressivo.sv
// 100 Hz countdown timer (ss:cc in BCD) with run/pause control, preset
// validation and a fixed-length alarm pulse at expiry.
module temporizador_regressivo
  import temporizador_regressivo_pkg::*;
#(
  parameter int ALARM_TICKS = 300
) (
  input  logic                       clk_100hz,
  input  logic                       reset,
  temporizador_regressivo_if.slave   ctrl
);

  localparam int                 CNT_W      = $clog2(ALARM_TICKS + 1);
  localparam logic [CNT_W-1:0]   ALARM_LAST = CNT_W'(ALARM_TICKS - 1);

  estado_t          estado_reg, estado_next;
  logic [3:0]       digito_reg  [NUM_DIGITOS];
  logic [3:0]       digito_next [NUM_DIGITOS];
  logic [3:0]       digito_dec  [NUM_DIGITOS];
  logic [3:0]       preset      [NUM_DIGITOS];
  logic [NUM_DIGITOS:0] borrow;
  logic             erro_reg, erro_next;
  logic [CNT_W-1:0] alarme_cnt_reg, alarme_cnt_next;
  logic             preset_ok;
  logic             contagem_zero;
  logic             chega_zero;
  logic             alarme_fim;

  assign preset[DIG_CS_U] = ctrl.p_cs_unidade;
  assign preset[DIG_CS_D] = ctrl.p_cs_dezena;
  assign preset[DIG_S_U]  = ctrl.p_s_unidade;
  assign preset[DIG_S_D]  = ctrl.p_s_dezena;

  assign preset_ok = preset_valido(ctrl.p_cs_unidade, ctrl.p_cs_dezena,
                                   ctrl.p_s_unidade, ctrl.p_s_dezena);

  // The least significant digit always borrows: one centisecond per step.
  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITOS; gi++) begin : g_digito
      decrementador_bcd #(
        .MAX_DIGIT (max_digito(gi))
      ) u_dec (
        .digito     (digito_reg[gi]),
        .borrow_in  (borrow[gi]),
        .digito_dec (digito_dec[gi]),
        .borrow_out (borrow[gi+1])
      );
    end
  endgenerate

  always_comb begin
    contagem_zero = 1'b1;
    chega_zero    = 1'b1;
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      if (digito_reg[i] != 4'd0) contagem_zero = 1'b0;
      if (digito_dec[i] != 4'd0) chega_zero    = 1'b0;
    end
    // A borrow out of the top digit would mean a wrap below 00:00; treat it as expiry.
    if (borrow[NUM_DIGITOS]) chega_zero = 1'b1;
  end

  assign alarme_fim = (estado_reg == ALARM) && (alarme_cnt_reg == ALARM_LAST);

  always_comb begin
    estado_next     = estado_reg;
    erro_next       = erro_reg;
    alarme_cnt_next = (estado_reg == ALARM) ? alarme_cnt_reg + 1'b1 : '0;
    for (int i = 0; i < NUM_DIGITOS; i++) digito_next[i] = digito_reg[i];

    if (ctrl.load && (estado_reg != RUN)) begin
      if (preset_ok) begin
        for (int i = 0; i < NUM_DIGITOS; i++) digito_next[i] = preset[i];
        erro_next   = 1'b0;
        estado_next = IDLE;
      end else begin
        // Rejected preset only raises erro; the alarm timeout still runs.
        erro_next = 1'b1;
        if (alarme_fim) estado_next = IDLE;
      end
    end else begin
      unique case (estado_reg)
        IDLE: begin
          if (ctrl.start_stop && !contagem_zero) estado_next = RUN;
        end
        RUN: begin
          if (ctrl.start_stop) begin
            estado_next = PAUSE;
          end else if (chega_zero) begin
            for (int i = 0; i < NUM_DIGITOS; i++) digito_next[i] = 4'd0;
            estado_next = ALARM;
          end else begin
            for (int i = 0; i < NUM_DIGITOS; i++) digito_next[i] = digito_dec[i];
          end
        end
        PAUSE: begin
          if (ctrl.start_stop) estado_next = RUN;
        end
        ALARM: begin
          if (ctrl.start_stop || alarme_fim) estado_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100hz) begin
    if (reset) begin
      estado_reg     <= IDLE;
      erro_reg       <= 1'b0;
      alarme_cnt_reg <= '0;
      for (int i = 0; i < NUM_DIGITOS; i++) digito_reg[i] <= 4'd0;
    end else begin
      estado_reg     <= estado_next;
      erro_reg       <= erro_next;
      alarme_cnt_reg <= alarme_cnt_next;
      for (int i = 0; i < NUM_DIGITOS; i++) digito_reg[i] <= digito_next[i];
    end
  end

  assign ctrl.cs_unidade = digito_reg[DIG_CS_U];
  assign ctrl.cs_dezena  = digito_reg[DIG_CS_D];
  assign ctrl.s_unidade  = digito_reg[DIG_S_U];
  assign ctrl.s_dezena   = digito_reg[DIG_S_D];
  assign ctrl.rodando    = (estado_reg == RUN);
  assign ctrl.alarme     = (estado_reg == ALARM);
  assign ctrl.erro       = erro_reg;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Directed scenarios plus random control traffic, checked every cycle against
// a centisecond-integer model of the countdown timer.
module tb_temporizador_regressivo;

  localparam int ALARM_TICKS = 300;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ALARM = 3;

  logic clk_100hz = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  int   m_st;
  int   m_total;
  bit   m_erro;
  int   m_left;

  always #5 clk_100hz = ~clk_100hz;

  temporizador_regressivo_if ctrl ();

  temporizador_regressivo #(
    .ALARM_TICKS (ALARM_TICKS)
  ) dut (
    .clk_100hz (clk_100hz),
    .reset     (reset),
    .ctrl      (ctrl)
  );

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input int t);
    return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  function automatic logic [31:0] contagem_dut();
    return {16'h0, ctrl.s_dezena, ctrl.s_unidade, ctrl.cs_dezena, ctrl.cs_unidade};
  endfunction

  // Remaining time kept as a plain number of centiseconds; alarm as cycles left.
  task automatic modelo(input bit rst, input bit ld, input bit ss,
                        input int pcu, input int pcd, input int psu, input int psd);
    bit ok;
    ok = (pcu <= 9) && (pcd <= 9) && (psu <= 9) && (psd <= 5);
    if (rst) begin
      m_st = M_IDLE; m_total = 0; m_erro = 0; m_left = 0;
    end else if (ld && m_st != M_RUN) begin
      if (ok) begin
        m_total = psd * 1000 + psu * 100 + pcd * 10 + pcu;
        m_erro  = 0;
        m_st    = M_IDLE;
      end else begin
        m_erro = 1;
        if (m_st == M_ALARM) begin
          m_left--;
          if (m_left == 0) m_st = M_IDLE;
        end
      end
    end else begin
      case (m_st)
        M_IDLE:  if (ss && m_total != 0) m_st = M_RUN;
        M_PAUSE: if (ss) m_st = M_RUN;
        M_RUN: begin
          if (ss) m_st = M_PAUSE;
          else begin
            m_total--;
            if (m_total == 0) begin
              m_st   = M_ALARM;
              m_left = ALARM_TICKS;
            end
          end
        end
        default: begin
          if (ss) m_st = M_IDLE;
          else begin
            m_left--;
            if (m_left == 0) m_st = M_IDLE;
          end
        end
      endcase
    end
  endtask

  // Called at a falling edge: drive, take the rising edge, check at the next falling edge.
  task automatic ciclo(input bit rst, input bit ld, input bit ss,
                       input int pcu, input int pcd, input int psu, input int psd);
    reset             = rst;
    ctrl.load         = ld;
    ctrl.start_stop   = ss;
    ctrl.p_cs_unidade = 4'(pcu);
    ctrl.p_cs_dezena  = 4'(pcd);
    ctrl.p_s_unidade  = 4'(psu);
    ctrl.p_s_dezena   = 4'(psd);
    @(posedge clk_100hz);
    modelo(rst, ld, ss, pcu, pcd, psu, psd);
    @(negedge clk_100hz);
    if (rst || ld || ss)
      $display("tx t=%0t rst=%0b load=%0b ss=%0b preset=%0d%0d:%0d%0d -> count=%04h st=%0d erro=%0b",
               $time, rst, ld, ss, psd, psu, pcd, pcu, enc(m_total), m_st, m_erro);
    verifica("count",   contagem_dut(), {16'h0, enc(m_total)});
    verifica("rodando", {31'h0, ctrl.rodando}, {31'h0, m_st == M_RUN});
    verifica("alarme",  {31'h0, ctrl.alarme},  {31'h0, m_st == M_ALARM});
    verifica("erro",    {31'h0, ctrl.erro},    {31'h0, m_erro});
  endtask

  task automatic carregar(input int sd, input int su, input int cd, input int cu);
    ciclo(1'b0, 1'b1, 1'b0, cu, cd, su, sd);
  endtask

  task automatic pulso();
    ciclo(1'b0, 1'b0, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 15));
  endtask

  task automatic espera(input int n);
    for (int i = 0; i < n; i++)
      ciclo(1'b0, 1'b0, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15));
  endtask

  function automatic int dig(input int maxv);
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, maxv));
  endfunction

  initial begin
    m_st = M_IDLE; m_total = 0; m_erro = 0; m_left = 0;
    ciclo(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    ciclo(1'b1, 1'b1, 1'b1, 5, 5, 5, 5);
    verifica("reset_count", contagem_dut(), 32'h0);

    // Scenario 1: 00:05 runs out into a full-length alarm.
    carregar(0, 0, 0, 5);
    pulso();
    espera(4);
    verifica("s1_count_01", contagem_dut(), 32'h0001);
    espera(1);
    verifica("s1_alarm_rise", {31'h0, ctrl.alarme}, 32'h1);
    espera(ALARM_TICKS - 1);
    verifica("s1_alarm_last", {31'h0, ctrl.alarme}, 32'h1);
    espera(1);
    verifica("s1_alarm_fall", {31'h0, ctrl.alarme}, 32'h0);

    // Scenario 2: second borrow, then start refused at 00:00.
    carregar(1, 0, 0, 0);
    pulso();
    espera(1);
    verifica("s2_borrow", contagem_dut(), 32'h0999);
    pulso();
    carregar(0, 0, 0, 0);
    pulso();
    verifica("s2_zero_start", {31'h0, ctrl.rodando}, 32'h0);

    // Scenario 3: pause freezes, resume continues.
    carregar(0, 0, 5, 0);
    pulso();
    espera(3);
    pulso();
    espera(2);
    verifica("s3_frozen", contagem_dut(), 32'h0047);
    pulso();
    espera(1);
    verifica("s3_resume", contagem_dut(), 32'h0046);

    // Scenario 4: rejected preset while paused, then a valid one.
    pulso();
    carregar(6, 0, 0, 0);
    verifica("s4_erro_set", {31'h0, ctrl.erro}, 32'h1);
    verifica("s4_count_kept", contagem_dut(), 32'h0046);
    carregar(0, 1, 0, 0);
    verifica("s4_erro_clear", {31'h0, ctrl.erro}, 32'h0);

    // Scenario 5: reset mid-run beats load/start_stop; load beats start_stop.
    carregar(1, 2, 3, 4);
    pulso();
    ciclo(1'b1, 1'b1, 1'b1, 9, 9, 9, 5);
    verifica("s5_reset_count", contagem_dut(), 32'h0);
    ciclo(1'b0, 1'b1, 1'b1, 0, 1, 0, 0);
    verifica("s5_load_wins", {31'h0, ctrl.rodando}, 32'h0);
    verifica("s5_loaded", contagem_dut(), 32'h0010);

    // Scenario 6: early acknowledge of the alarm.
    carregar(0, 0, 0, 1);
    pulso();
    espera(1);
    espera(2);
    pulso();
    verifica("s6_ack", {31'h0, ctrl.alarme}, 32'h0);

    // Random control traffic, biased towards short valid presets.
    for (int n = 0; n < 2500; n++) begin
      bit rst, ld, ss;
      int cu, cd, su, sd;
      rst = ($urandom_range(0, 299) == 0);
      ld  = ($urandom_range(0, 15) == 0);
      ss  = ($urandom_range(0, 9) == 0);
      cu  = dig(9);
      cd  = dig(9);
      su  = dig(9);
      sd  = dig(5);
      if ($urandom_range(0, 2) == 0) begin
        cd = 0; su = 0; sd = 0;
      end
      ciclo(rst, ld, ss, cu, cd, su, sd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
